uart_rx_fifo: RTL
=================

# uart_rx_fifo

UART receiver with a small receive FIFO for the rv32i SoC. It deserialises the asynchronous `rxd` line into bytes and buffers them for the CPU's memory-mapped UART read path. It sits directly behind the SoC's `RXD` pin, downstream of the external serial driver and upstream of the CPU load/store interface. The frame format is 8N1 by default. Even parity is optional.

## Interface
- `CLKS_PER_BIT`, 215, clock cycles per UART bit (10 MHz clock); must be ≥ 4
- `FIFO_DEPTH`, 8, receive FIFO entries; power of two, ≥ 2
- `clk`  in  1  system clock, rising-edge
- `resetn`  in  1  reset, asynchronous, active-low
- `rxd`  in  1  serial input, idle high, asynchronous to `clk`
- `rd_en`  in  1  pop head of FIFO; ignored when empty
- `rd_data`  out  8  FIFO head byte, first-word fall-through; 0 when empty
- `rx_valid`  out  1  FIFO not empty
- `rx_count`  out  $clog2(FIFO_DEPTH)+1  bytes held
- `overrun`  out  1  sticky: a byte was dropped because the FIFO was full
- `frame_err`  out  1  sticky: stop bit sampled low
- `err_clr`  in  1  clears `overrun`, `frame_err` (and `parity_err`) next cycle

## Operation
- **Input synchroniser:** `rxd` passes through two flops, both reset to 1. All logic uses the synchronised value `rxs`.
- **FSM states:** IDLE, START, DATA, STOP, (PARITY), WAIT_IDLE.
  - **IDLE:** `rxs`=0 → START, and the bit counter is cleared.
  - **START:** at count CLKS_PER_BIT/2−1, sample `rxs`. If 0, go to DATA and reload the counter. If 1, treat it as a false start and return to IDLE.
  - **DATA:** sample every CLKS_PER_BIT cycles from the mid-start point. Bits arrive LSB first into a shift register. After bit 7, go to STOP (or PARITY when parity is enabled).
  - **STOP:** sample at mid-bit.
    - If 1, push the byte and go to IDLE. This permits back-to-back frames.
    - If 0, set `frame_err`, discard the byte, and go to WAIT_IDLE.
  - **WAIT_IDLE:** stay until `rxs`=1, then go to IDLE. This means a break condition never retriggers reception.
- **FIFO:**
  - Push with the FIFO not full: the byte is stored.
  - Push with the FIFO full and no `rd_en`: the byte is dropped and `overrun` is set.
  - Push with the FIFO full and `rd_en` in the same cycle: the pop and the push both occur, and `overrun` is not set.
  - `rd_en` with the FIFO empty: no effect.
  - Pointers wrap modulo FIFO_DEPTH. `rx_count` changes by +1, −1 or 0 per cycle.
- **Sticky flags:** `err_clr` wins over a same-cycle set. The flag is then cleared and that event is lost.
- **Reset values:** all outputs are 0. The FSM is in IDLE and the FIFO is empty. Reset asserted mid-frame aborts the frame, and no partial byte is ever pushed.

## Timing
- Falling edge of `rxd` to FSM leaving IDLE: 2–3 cycles (synchroniser).
- A data bit is sampled CLKS_PER_BIT/2 (±1) cycles after its nominal start plus the synchroniser delay.
- Push occurs in the mid-stop sample cycle. `rx_valid`, `rx_count` and `rd_data` update on the following edge.
- `rd_en` pop: on the next edge `rd_data` shows the next entry, or 0 if the FIFO is now empty.
- The bit counter is $clog2(CLKS_PER_BIT) bits wide and counts up, saturating only through its reload.

## Configuration
- **`UART_RX_PARITY_EN` defined:**
  - A PARITY state follows DATA. It samples one even-parity bit at mid-bit.
  - On mismatch, a sticky `parity_err` output (1 bit, reset 0, cleared by `err_clr`) is set. The byte is discarded, but the STOP check still proceeds.
- **Undefined:** the block is 8N1. There is no PARITY state and no `parity_err` port.

## Structure
- Package `uart_pkg`:
  - the FSM state enum
  - `UART_DATA_BITS` = 8
  - the idle line level
- Sub-module `sync_fifo`:
  - parameterised width and depth
  - FWFT read
  - count output
  - simultaneous push/pop when full is allowed
- The receiver FSM, the synchroniser and the sticky flags stay in `uart_rx_fifo`.

## Test plan
1. Send 0x35 at 215 clocks/bit → one push, `rx_valid`=1, `rd_data`=0x35, `rx_count`=1. Pulse `rd_en` → `rx_valid`=0, `rd_data`=0.
2. Send 0x35, 0x37, 0x38, 0x0D back-to-back with no idle gap → `rx_count`=4. Four pops return the bytes in order, with no `frame_err` and no `overrun`.
3. Drive `rxd` low for 50 cycles, then high → false start. Nothing is pushed and the FSM returns to IDLE.
4. Send 0x31 with the stop bit low, then hold low for 1000 cycles → `frame_err`=1, `rx_count`=0. Release high and send 0x34 → 0x34 is received. `err_clr` → `frame_err`=0.
5. Send 9 bytes 0x00–0x08 without reading → `rx_count`=8, `overrun`=1, and the pops return 0x00–0x07. Repeat with `rd_en` asserted in the ninth push cycle → `overrun` stays 0.
6. Assert `resetn` low during data bit 4, then release and send 0x0D → only 0x0D appears. With `UART_RX_PARITY_EN` defined, send 0x37 with wrong parity → `parity_err`=1 and nothing is pushed.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared definitions for the UART receive path: receiver FSM states,
// frame data width and the idle level of the serial line.
// UART_RX_PARITY_EN adds the PARITY state to the state set.
package uart_pkg;

    localparam int   UART_DATA_BITS = 8;
    localparam logic UART_IDLE_LVL  = 1'b1;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
`ifdef UART_RX_PARITY_EN
        ST_PARITY,
`endif
        ST_STOP,
        ST_WAIT_IDLE
    } rx_state_e;

endpackage

// File: rtl/sync_fifo.sv
// Small synchronous FIFO with first-word fall-through read and an
// occupancy count. A push into a full FIFO is accepted when a pop
// happens in the same cycle. The head reads as zero while empty.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic                       clk,
    input  logic                       resetn,
    input  logic                       push,
    input  logic [WIDTH-1:0]           din,
    input  logic                       pop,
    output logic [WIDTH-1:0]           dout,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       full,
    output logic                       empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wptr;
    logic [AW-1:0]    rptr;
    logic             do_push;
    logic             do_pop;

    assign empty   = (count == '0);
    assign full    = (count == (AW+1)'(DEPTH));
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign dout    = empty ? '0 : mem[rptr];

    // Storage array; contents are only visible through count, so no reset.
    always_ff @(posedge clk) begin
        if (do_push) mem[wptr] <= din;
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (do_push) wptr <= wptr + 1'b1;
            if (do_pop)  rptr <= rptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/uart_rx_fifo.sv
// UART receiver (8N1, optional even parity) feeding a small FWFT FIFO.
// Holds the rxd synchroniser, the bit-timing FSM and the sticky error
// flags. Define UART_RX_PARITY_EN to add the parity bit and parity_err.
module uart_rx_fifo
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 215,
    parameter int FIFO_DEPTH   = 8
) (
    input  logic                          clk,
    input  logic                          resetn,
    input  logic                          rxd,
    input  logic                          rd_en,
    output logic [7:0]                    rd_data,
    output logic                          rx_valid,
    output logic [$clog2(FIFO_DEPTH):0]   rx_count,
    output logic                          overrun,
    output logic                          frame_err,
`ifdef UART_RX_PARITY_EN
    output logic                          parity_err,
`endif
    input  logic                          err_clr
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam int IDX_W = $clog2(UART_DATA_BITS);
    localparam logic [CNT_W-1:0] HALF_M1 = CNT_W'(CLKS_PER_BIT/2 - 1);
    localparam logic [CNT_W-1:0] FULL_M1 = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(UART_DATA_BITS - 1);

    logic [1:0]                sync_q;
    logic                      rxs;
    rx_state_e                 state;
    logic [CNT_W-1:0]          cnt;
    logic [IDX_W-1:0]          bit_idx;
    logic [UART_DATA_BITS-1:0] shreg;
    logic                      par_bad;
    logic                      bit_done;
    logic                      push;
    logic                      frame_set;
    logic                      fifo_full;
    logic                      fifo_empty;

    assign rxs      = sync_q[1];
    assign bit_done = (cnt == FULL_M1);

    // Push and the framing error are decoded in the mid-stop sample cycle
    // itself, so the FIFO sees the byte on that same edge.
    assign push      = (state == ST_STOP) && bit_done && (rxs == UART_IDLE_LVL) && !par_bad;
    assign frame_set = (state == ST_STOP) && bit_done && (rxs != UART_IDLE_LVL);

    // Two-flop synchroniser, reset to the idle line level.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) sync_q <= {2{UART_IDLE_LVL}};
        else         sync_q <= {sync_q[0], rxd};
    end

    // Receiver FSM: start qualification at mid-bit, then one sample per bit.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state   <= ST_IDLE;
            cnt     <= '0;
            bit_idx <= '0;
            shreg   <= '0;
`ifdef UART_RX_PARITY_EN
            par_bad <= 1'b0;
`endif
        end else begin
            case (state)
                ST_IDLE: begin
                    cnt <= '0;
                    if (rxs != UART_IDLE_LVL) state <= ST_START;
                end
                ST_START: begin
                    if (cnt == HALF_M1) begin
                        cnt     <= '0;
                        bit_idx <= '0;
`ifdef UART_RX_PARITY_EN
                        par_bad <= 1'b0;
`endif
                        state   <= (rxs != UART_IDLE_LVL) ? ST_DATA : ST_IDLE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                ST_DATA: begin
                    if (bit_done) begin
                        cnt   <= '0;
                        shreg <= {rxs, shreg[UART_DATA_BITS-1:1]};
                        if (bit_idx == LAST_IDX) begin
`ifdef UART_RX_PARITY_EN
                            state <= ST_PARITY;
`else
                            state <= ST_STOP;
`endif
                        end else begin
                            bit_idx <= bit_idx + 1'b1;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
`ifdef UART_RX_PARITY_EN
                ST_PARITY: begin
                    if (bit_done) begin
                        cnt     <= '0;
                        par_bad <= ((^shreg) != rxs);
                        state   <= ST_STOP;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
`endif
                ST_STOP: begin
                    if (bit_done) begin
                        cnt   <= '0;
                        state <= (rxs == UART_IDLE_LVL) ? ST_IDLE : ST_WAIT_IDLE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                ST_WAIT_IDLE: begin
                    if (rxs == UART_IDLE_LVL) state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

`ifndef UART_RX_PARITY_EN
    assign par_bad = 1'b0;
`endif

    // Sticky error flags; a clear request beats a same-cycle set.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            overrun   <= 1'b0;
            frame_err <= 1'b0;
        end else if (err_clr) begin
            overrun   <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            if (push && fifo_full && !rd_en) overrun <= 1'b1;
            if (frame_set)                   frame_err <= 1'b1;
        end
    end

`ifdef UART_RX_PARITY_EN
    // Sticky parity flag, set at the stop sample of a frame with bad parity.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn)                               parity_err <= 1'b0;
        else if (err_clr)                          parity_err <= 1'b0;
        else if ((state == ST_STOP) && bit_done && par_bad) parity_err <= 1'b1;
    end
`endif

    sync_fifo #(
        .WIDTH (UART_DATA_BITS),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk    (clk),
        .resetn (resetn),
        .push   (push),
        .din    (shreg),
        .pop    (rd_en),
        .dout   (rd_data),
        .count  (rx_count),
        .full   (fifo_full),
        .empty  (fifo_empty)
    );

    assign rx_valid = !fifo_empty;

endmodule
